// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: digit count, blank pattern and the hex glyph
// table. Glyphs are {g,f,e,d,c,b,a} and active-low (0 lights a segment).
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

endpackage

// File: rtl/hex_to_seven_seg.sv
// Combinational 4-bit hex nibble to active-low 7-segment glyph lookup.
module hex_to_seven_seg
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  // Map the nibble onto its glyph; anything unexpected blanks the digit.
  always_comb begin
    segments = SEG_BLANK;
    case (nibble)
      4'h0:    segments = GLYPH_0;
      4'h1:    segments = GLYPH_1;
      4'h2:    segments = GLYPH_2;
      4'h3:    segments = GLYPH_3;
      4'h4:    segments = GLYPH_4;
      4'h5:    segments = GLYPH_5;
      4'h6:    segments = GLYPH_6;
      4'h7:    segments = GLYPH_7;
      4'h8:    segments = GLYPH_8;
      4'h9:    segments = GLYPH_9;
      4'hA:    segments = GLYPH_A;
      4'hB:    segments = GLYPH_B;
      4'hC:    segments = GLYPH_C;
      4'hD:    segments = GLYPH_D;
      4'hE:    segments = GLYPH_E;
      4'hF:    segments = GLYPH_F;
      default: segments = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_trace_display.sv
// Trace viewer for the pipeline's PC / write-data debug outputs. Every change
// of the {PC, WriteData} pair is queued in a small FIFO; each press of the
// step button pops one entry onto an 8-digit multiplexed 7-seg display
// (PC[15:0] on digits 7..4, WriteData[15:0] on digits 3..0).
module seven_seg_trace_display
  import seg7_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [31:0]                PCIn,
  input  logic [31:0]                DataIn,
  input  logic                       StepBtn,
  output logic [7:0]                 Anode,
  output logic [6:0]                 Cathode,
  output logic                       DP,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       Overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [2:0]       SEP_DIGIT = 3'd4;

  // Capture path
  logic [63:0]      pairNow_s;
  logic [63:0]      prevPair_r;
  logic [31:0]      fifoMem_r [DEPTH];
  logic [PTR_W-1:0] wrPtr_r;
  logic [PTR_W-1:0] rdPtr_r;
  logic [CNT_W-1:0] count_r;
  logic             overflow_r;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;
  logic             pushAccept_s;
  logic             dropPush_s;

  // Step button path
  logic             stepSync1_r;
  logic             stepSync2_r;
  logic             stepPrev_r;
  logic             stepPulse_r;

  // Shown entry and scan
  logic [15:0]      shownPc_r;
  logic [15:0]      shownData_r;
  logic [DIV_W-1:0] divCnt_r;
  logic [2:0]       digitIdx_r;
  logic [31:0]      shownWord_s;
  logic [3:0]       nibble_s;
  logic [6:0]       glyph_s;
  logic [7:0]       anodeNext_s;
  logic             dpNext_s;
  logic [7:0]       anode_r;
  logic [6:0]       cathode_r;
  logic             dp_r;

  // FIFO control: detect a new pair and decide whether it is stored or dropped.
  always_comb begin
    pairNow_s    = {PCIn, DataIn};
    push_s       = (pairNow_s != prevPair_r);
    empty_s      = (count_r == CNT_ZERO);
    full_s       = (count_r == CNT_FULL);
    pop_s        = stepPulse_r && !empty_s;
    // A pop on the same edge frees the slot the push needs.
    pushAccept_s = push_s && (!full_s || pop_s);
    dropPush_s   = push_s && full_s && !pop_s;
  end

  // Storage array; no reset because pointer reset already discards contents.
  always_ff @(posedge Clk) begin
    if (pushAccept_s) begin
      fifoMem_r[wrPtr_r] <= {PCIn[15:0], DataIn[15:0]};
    end
  end

  // Previous-pair register, pointers, occupancy, sticky overflow and shown entry.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      prevPair_r  <= 64'd0;
      wrPtr_r     <= {PTR_W{1'b0}};
      rdPtr_r     <= {PTR_W{1'b0}};
      count_r     <= CNT_ZERO;
      overflow_r  <= 1'b0;
      shownPc_r   <= 16'd0;
      shownData_r <= 16'd0;
    end else begin
      prevPair_r <= pairNow_s;
      if (pushAccept_s) begin
        wrPtr_r <= wrPtr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rdPtr_r     <= rdPtr_r + PTR_W'(1);
        shownPc_r   <= fifoMem_r[rdPtr_r][31:16];
        shownData_r <= fifoMem_r[rdPtr_r][15:0];
      end
      case ({pushAccept_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (dropPush_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Step button: two-flop synchroniser, rising-edge detect, registered one-cycle pulse.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      stepSync1_r <= 1'b0;
      stepSync2_r <= 1'b0;
      stepPrev_r  <= 1'b0;
      stepPulse_r <= 1'b0;
    end else begin
      stepSync1_r <= StepBtn;
      stepSync2_r <= stepSync1_r;
      stepPrev_r  <= stepSync2_r;
      stepPulse_r <= stepSync2_r && !stepPrev_r;
    end
  end

  // Refresh divider and digit index; the index advances on divider terminal count.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      divCnt_r   <= {DIV_W{1'b0}};
      digitIdx_r <= 3'd0;
    end else if (divCnt_r == DIV_LAST) begin
      divCnt_r   <= {DIV_W{1'b0}};
      digitIdx_r <= digitIdx_r + 3'd1;
    end else begin
      divCnt_r   <= divCnt_r + DIV_W'(1);
      digitIdx_r <= digitIdx_r;
    end
  end

  // Select the nibble and decimal point for the digit currently being scanned.
  always_comb begin
    shownWord_s = {shownPc_r, shownData_r};
    nibble_s    = shownWord_s[{digitIdx_r, 2'b00} +: 4];
    anodeNext_s = ~(8'b0000_0001 << digitIdx_r);
    if (digitIdx_r == SEP_DIGIT) begin
      dpNext_s = 1'b0;
    end else if ((digitIdx_r == 3'd0) && overflow_r) begin
      dpNext_s = 1'b0;
    end else begin
      dpNext_s = 1'b1;
    end
  end

  hex_to_seven_seg u_hexToSevenSeg (
    .nibble   (nibble_s),
    .segments (glyph_s)
  );

  // Register the display drive so anode, segments and DP switch together.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      anode_r   <= 8'hFE;
      cathode_r <= GLYPH_0;
      dp_r      <= 1'b1;
    end else begin
      anode_r   <= anodeNext_s;
      cathode_r <= glyph_s;
      dp_r      <= dpNext_s;
    end
  end

  assign Anode    = anode_r;
  assign Cathode  = cathode_r;
  assign DP       = dp_r;
  assign Count    = count_r;
  assign Overflow = overflow_r;

  // NUM_DIGITS documents the scan width; the index is 3 bits for 8 digits.
  localparam int SCAN_DIGITS = NUM_DIGITS;

endmodule

// File: tb/tb_seven_seg_trace_display.sv
// Directed bench for seven_seg_trace_display: reset state, capture, stepping,
// overflow, simultaneous push/pop on a full FIFO and the digit scan order.
module tb_seven_seg_trace_display;

  localparam int DEPTH       = 8;
  localparam int REFRESH_DIV = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] PCIn;
  logic [31:0] DataIn;
  logic        StepBtn;
  logic [7:0]  Anode;
  logic [6:0]  Cathode;
  logic        DP;
  logic [3:0]  Count;
  logic        Overflow;

  int assertCount = 0;
  int failCount   = 0;

  logic [6:0] expGlyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seven_seg_trace_display #(
    .DEPTH       (DEPTH),
    .REFRESH_DIV (REFRESH_DIV)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .PCIn     (PCIn),
    .DataIn   (DataIn),
    .StepBtn  (StepBtn),
    .Anode    (Anode),
    .Cathode  (Cathode),
    .DP       (DP),
    .Count    (Count),
    .Overflow (Overflow)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic pressStep();
    StepBtn = 1'b1;
    tick(2);
    StepBtn = 1'b0;
    tick(4);
  endtask

  // Wait (bounded) for digit k to be lit, then check its glyph and DP.
  task automatic checkDigit(input int k, input logic [6:0] glyph, input logic dp);
    logic [7:0] expA;
    bit found;
    expA  = ~(8'b0000_0001 << k);
    found = 1'b0;
    for (int i = 0; i < 48; i++) begin
      @(negedge Clk);
      if (Anode === expA) begin
        found = 1'b1;
        break;
      end
    end
    chk($sformatf("digit%0d_lit", k), {63'd0, found}, 64'd1);
    chk($sformatf("digit%0d_seg", k), {57'd0, Cathode}, {57'd0, glyph});
    chk($sformatf("digit%0d_dp", k), {63'd0, DP}, {63'd0, dp});
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset state
    Reset = 1'b0; PCIn = 32'd0; DataIn = 32'd0; StepBtn = 1'b0;
    tick(3);
    @(negedge Clk);
    chk("rst_anode", {56'd0, Anode}, 64'hFE);
    chk("rst_cathode", {57'd0, Cathode}, 64'h40);
    chk("rst_dp", {63'd0, DP}, 64'd1);
    chk("rst_count", {60'd0, Count}, 64'd0);
    chk("rst_ovf", {63'd0, Overflow}, 64'd0);
    @(posedge Clk); #1;
    Reset = 1'b1;

    // 2: one capture, no repeat while inputs are stable
    PCIn = 32'h8; DataIn = 32'h2A;
    tick(1);
    chk("cap_count1", {60'd0, Count}, 64'd1);
    tick(20);
    chk("cap_stable", {60'd0, Count}, 64'd1);

    // 3: held button gives one pop; display shows 0008 / 002A
    StepBtn = 1'b1;
    tick(10);
    StepBtn = 1'b0;
    tick(4);
    chk("step_count0", {60'd0, Count}, 64'd0);
    checkDigit(0, expGlyph[10], 1'b1);
    checkDigit(1, expGlyph[2], 1'b1);
    checkDigit(4, expGlyph[8], 1'b0);
    checkDigit(7, expGlyph[0], 1'b1);
    pressStep();
    chk("empty_step_count", {60'd0, Count}, 64'd0);
    checkDigit(0, expGlyph[10], 1'b1);
    checkDigit(4, expGlyph[8], 1'b0);

    // 4: nine pushes into an 8-deep FIFO
    for (int i = 1; i <= 9; i++) begin
      PCIn = 32'h100 + i; DataIn = 32'h200 + i;
      tick(1);
    end
    chk("full_count", {60'd0, Count}, 64'd8);
    chk("full_ovf", {63'd0, Overflow}, 64'd1);
    checkDigit(0, expGlyph[10], 1'b0);
    for (int i = 1; i <= 8; i++) begin
      pressStep();
      chk($sformatf("drain_count%0d", i), {60'd0, Count}, 64'(8 - i));
      checkDigit(0, expGlyph[i], 1'b0);
      checkDigit(4, expGlyph[i], 1'b0);
    end
    pressStep();
    chk("ninth_absent_count", {60'd0, Count}, 64'd0);
    checkDigit(0, expGlyph[8], 1'b0);
    checkDigit(2, expGlyph[2], 1'b1);
    checkDigit(6, expGlyph[1], 1'b1);
    chk("ovf_sticky", {63'd0, Overflow}, 64'd1);

    // 5: full FIFO, push on the same edge as a pop
    Reset = 1'b0; PCIn = 32'd0; DataIn = 32'd0;
    tick(2);
    Reset = 1'b1;
    chk("rst2_count", {60'd0, Count}, 64'd0);
    chk("rst2_ovf", {63'd0, Overflow}, 64'd0);
    for (int i = 1; i <= 8; i++) begin
      PCIn = 32'h300 + i; DataIn = 32'h400 + i;
      tick(1);
    end
    chk("fill_count", {60'd0, Count}, 64'd8);
    chk("fill_ovf", {63'd0, Overflow}, 64'd0);
    StepBtn = 1'b1;
    tick(3);
    PCIn = 32'h309; DataIn = 32'h409; StepBtn = 1'b0;
    tick(1);
    chk("simul_count", {60'd0, Count}, 64'd8);
    chk("simul_ovf", {63'd0, Overflow}, 64'd0);
    tick(3);
    checkDigit(0, expGlyph[1], 1'b1);
    for (int i = 0; i < 8; i++) begin
      pressStep();
    end
    chk("simul_drained", {60'd0, Count}, 64'd0);
    checkDigit(0, expGlyph[9], 1'b1);
    checkDigit(4, expGlyph[9], 1'b0);

    // 6: scan order and timing with REFRESH_DIV=4
    Reset = 1'b0;
    tick(2);
    Reset = 1'b1;
    for (int c = 0; c <= 36; c++) begin
      int idx;
      logic [7:0] expA;
      @(negedge Clk);
      idx  = (c == 0) ? 0 : (((c - 1) / 4) % 8);
      expA = ~(8'b0000_0001 << idx);
      chk($sformatf("scan_c%0d", c), {56'd0, Anode}, {56'd0, expA});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
